// File: rtl/mpi_pkg.sv
// Shared types and constants for the MPI receive path: header layout, magic and FSM states.
package mpi_pkg;

  localparam int unsigned N_WORD    = 128;
  localparam int unsigned HDR_LEN_W = 16;

  // Header field positions inside a 128-bit header word; bits [63:0] are reserved.
  localparam int unsigned SRC_LSB   = 120;
  localparam int unsigned DST_LSB   = 112;
  localparam int unsigned TAG_LSB   = 96;
  localparam int unsigned LEN_LSB   = 80;
  localparam int unsigned MAGIC_LSB = 64;

  localparam logic [15:0] HDR_MAGIC = 16'hA5C3;

  typedef struct packed {
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [15:0] tag;
    logic [15:0] len;
    logic [15:0] magic;
  } mpi_hdr_t;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DROP
  } rx_state_t;

endpackage

// File: rtl/mpi_skid2.sv
// Two-entry register FIFO that absorbs the one-cycle FIFO read latency.
// Entry 0 is always the head; simultaneous push and pop keep the count and the order.
module mpi_skid2 #(
  parameter int unsigned W = 128
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;

  // Storage and occupancy update.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = e0;

  // The read-request throttle guarantees a returning word always finds a free slot.
  assert property (@(posedge clock) disable iff (reset) !(push && (count == 2'd2)));

endmodule

// File: rtl/mpi_rx_unpacker.sv
// Read-side consumer of the RX message FIFO: parses one header per message, streams payload
// words downstream with valid/ready/last, and discards messages addressed to other ranks.
// Optional statistics outputs are enabled by defining MPI_RX_STATS_EN.
module mpi_rx_unpacker
  import mpi_pkg::*;
#(
  parameter int unsigned N     = N_WORD,
  parameter int unsigned LEN_W = HDR_LEN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     fifo_data,
  input  logic             fifo_valid,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [7:0]       my_rank,
  output logic             hdr_valid,
  input  logic             hdr_ready,
  output logic [7:0]       hdr_src,
  output logic [15:0]      hdr_tag,
  output logic [LEN_W-1:0] hdr_len,
  output logic [N-1:0]     pl_data,
  output logic             pl_valid,
  input  logic             pl_ready,
  output logic             pl_last,
  output logic             drop_pulse,
  output logic             err_pulse
`ifdef MPI_RX_STATS_EN
  ,
  output logic [31:0]      stat_msgs,
  output logic [31:0]      stat_drops,
  output logic [31:0]      stat_errs
`endif
);

  logic [1:0]       skid_count;
  logic [N-1:0]     head;
  logic             head_present;
  logic             pop;
  logic             inflight;
  mpi_hdr_t         hdr;

  rx_state_t        state, state_n;
  logic [LEN_W-1:0] remaining, remaining_n;
  logic [7:0]       src_q, src_n;
  logic [15:0]      tag_q, tag_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic             drop_q, drop_n;
  logic             err_q, err_n;

  mpi_skid2 #(.W(N)) u_skid (
    .clock (clock),
    .reset (reset),
    .push  (fifo_valid),
    .pop   (pop),
    .din   (fifo_data),
    .count (skid_count),
    .head  (head)
  );

  assign head_present = (skid_count != 2'd0);

  assign hdr = '{src:   head[SRC_LSB   +: 8],
                 dst:   head[DST_LSB   +: 8],
                 tag:   head[TAG_LSB   +: 16],
                 len:   head[LEN_LSB   +: 16],
                 magic: head[MAGIC_LSB +: 16]};

  // Request a word only when a slot is guaranteed for it, counting the one already in flight.
  assign fifo_rd = !reset && !fifo_empty && ((skid_count + 2'(inflight)) < 2'd2);

  // Track whether a word is due back next cycle.
  always_ff @(posedge clock) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= fifo_rd;
  end

  // FSM state and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      src_q     <= '0;
      tag_q     <= '0;
      len_q     <= '0;
      drop_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      src_q     <= src_n;
      tag_q     <= tag_n;
      len_q     <= len_n;
      drop_q    <= drop_n;
      err_q     <= err_n;
    end
  end

  // Next-state logic: header parse, header handoff, payload stream, discard.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    src_n       = src_q;
    tag_n       = tag_q;
    len_n       = len_q;
    drop_n      = 1'b0;
    err_n       = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (head_present) begin
          pop = 1'b1;
          if (hdr.magic != HDR_MAGIC) begin
            err_n = 1'b1;
          end else if (hdr.dst != my_rank) begin
            drop_n      = 1'b1;
            remaining_n = LEN_W'(hdr.len);
            if (hdr.len != 16'd0) state_n = DROP;
          end else begin
            src_n       = hdr.src;
            tag_n       = hdr.tag;
            len_n       = LEN_W'(hdr.len);
            remaining_n = LEN_W'(hdr.len);
            state_n     = HDR;
          end
        end
      end
      HDR: begin
        if (hdr_ready) state_n = (len_q == '0) ? IDLE : PAYLOAD;
      end
      PAYLOAD: begin
        if (head_present && pl_ready) begin
          pop         = 1'b1;
          remaining_n = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state_n = IDLE;
        end
      end
      DROP: begin
        if (head_present) begin
          pop         = 1'b1;
          remaining_n = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign hdr_valid  = (state == HDR);
  assign hdr_src    = src_q;
  assign hdr_tag    = tag_q;
  assign hdr_len    = len_q;
  assign pl_valid   = (state == PAYLOAD) && head_present;
  assign pl_data    = pl_valid ? head : '0;
  assign pl_last    = pl_valid && (remaining == LEN_W'(1));
  assign drop_pulse = drop_q;
  assign err_pulse  = err_q;

`ifdef MPI_RX_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_msgs  <= '0;
      stat_drops <= '0;
      stat_errs  <= '0;
    end else begin
      if (hdr_valid && hdr_ready && (stat_msgs != 32'hFFFF_FFFF)) stat_msgs <= stat_msgs + 32'd1;
      if (drop_n && (stat_drops != 32'hFFFF_FFFF)) stat_drops <= stat_drops + 32'd1;
      if (err_n && (stat_errs != 32'hFFFF_FFFF)) stat_errs <= stat_errs + 32'd1;
    end
  end
`endif

endmodule
